aes_byte_serializer: RTL
========================

Name: aes_byte_serializer

Overview:
Transmit-side counterpart of the byte-serial `encrypt` input interface. It accepts a 128-bit plaintext block and a 128-bit key in parallel, then drives them out one byte per clock on `in_byte`/`key_byte` with an `enable` strobe, in the order the encrypt core consumes them (FIPS-197 byte 0 first). It sits between the host/block buffer and `encrypt`, and supports a downstream stall (`hold`) and a completion pulse.

Parameters:
BLOCK_BYTES, 16, number of bytes per block and per key; the counter width is clog2(BLOCK_BYTES).
BYTE_W, 8, width of each serial byte lane.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  request to load `message`/`key_in`; sampled only in IDLE.
message  input  128  plaintext block; bits [127:120] are byte 0.
key_in  input  128  cipher key; bits [127:120] are byte 0.
hold  input  1  downstream stall; while high in SEND, no byte is emitted or advanced.
busy  output  1  high whenever the state is not IDLE.
in_byte  output  8  current plaintext byte (upper byte of the data shift register).
key_byte  output  8  current key byte (upper byte of the key shift register).
enable  output  1  byte-valid strobe; connects to `encrypt.enable`.
last  output  1  high together with `enable` on byte 15.
done  output  1  one-cycle pulse after the final byte is transferred.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, cnt=0, both shift registers = 0.
  - Outputs: in_byte=0, key_byte=0, enable=0, last=0, done=0, busy=0.
  - Reset asserted mid-transfer aborts immediately; no done pulse is generated.
- States: IDLE, SEND, DONE.
- IDLE:
  - On start=1 at an edge: data_sr<=message, key_sr<=key_in, cnt<=0, state<=SEND.
  - If start=0, stay in IDLE.
  - `hold` is ignored in IDLE.
- SEND:
  - enable = (state==SEND) & ~hold (combinational from `hold`, zero-cycle stall response).
  - in_byte = data_sr[127:120], key_byte = key_sr[127:120].
  - At an edge with enable=1: both shift registers shift left by 8 with zero fill, cnt<=cnt+1.
  - If cnt==BLOCK_BYTES-1 on that edge, state<=DONE.
  - At an edge with hold=1: shift registers and cnt are unchanged, and the byte outputs stay stable.
- last = enable & (cnt==BLOCK_BYTES-1).
- DONE:
  - done=1 for exactly one cycle; state<=IDLE unconditionally.
  - start is ignored in DONE.
- start asserted while busy=1 (SEND or DONE) is ignored; the inputs are not re-captured.
- Latency:
  - The start edge is followed by byte 0 with enable=1 in the next cycle (provided hold=0).
  - With no stalls: 16 enable cycles, then done, so 17 cycles from the start edge to done high.
  - The earliest next start is accepted in the cycle done is high +1, i.e. IDLE is re-entered after DONE.
- Each stall cycle extends the transfer by exactly one cycle; there is no byte loss and no duplication.
- Wrap: cnt never exceeds BLOCK_BYTES-1 inside SEND; it is reset to 0 on every load.
- Outputs in_byte/key_byte are don't-care-but-deterministic (zero after 16 shifts) outside SEND.

Test Plan:
1. FIPS-197 vector: message=3243f6a8885a308d313198a2e0370734, key_in=2b7e151628aed2a6abf7158809cf4f3c, pulse start, hold=0.
   - Expect 16 consecutive enable cycles: in_byte 32,43,f6,a8,…,07,34 and key_byte 2b,7e,15,16,…,4f,3c.
   - last is high only with 34/3c; done pulses on the next cycle.
2. Same vector, with hold=1 during byte indices 3 and 4 (2 cycles each).
   - enable=0 during the stalls, with in_byte held at a8 then 88.
   - The full 16-byte sequence is unchanged; done arrives 4 cycles later than in scenario 1.
3. start re-asserted with a different message (all ff) during byte 7 of a transfer.
   - The stream continues with the original bytes; busy stays high; no restart occurs.
4. resetn pulled low during byte 9.
   - All outputs go to 0 immediately and busy=0; done never pulses.
   - After release, start with the same vector produces the full sequence from byte 32.
5. Back-to-back transfers: start held high continuously with message=00112233445566778899aabbccddeeff.
   - A second transfer begins on the edge after done; the byte streams are identical, with exactly 1 IDLE cycle (busy=0) between them.
6. start=1 and hold=1 simultaneously in IDLE.
   - The load occurs; enable stays 0 until hold drops; the first emitted byte is byte 0 (00).

Source files
------------

// File: rtl/aes_byte_serializer.sv
// rtl/aes_byte_serializer.sv - loads a plaintext block and key in parallel and streams them byte-serially to encrypt
module aes_byte_serializer #(
    parameter int BLOCK_BYTES = 16,
    parameter int BYTE_W      = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [BLOCK_BYTES*BYTE_W-1:0] message,
    input  logic [BLOCK_BYTES*BYTE_W-1:0] key_in,
    input  logic                          hold,
    output logic                          busy,
    output logic [BYTE_W-1:0]             in_byte,
    output logic [BYTE_W-1:0]             key_byte,
    output logic                          enable,
    output logic                          last,
    output logic                          done
);

    localparam int W     = BLOCK_BYTES * BYTE_W;
    localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]     data_sr, data_nxt;
    logic [W-1:0]     key_sr, key_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            data_sr <= '0;
            key_sr  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            data_sr <= data_nxt;
            key_sr  <= key_nxt;
        end
    end

    // enable follows hold combinationally so a stall takes effect in the same cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_sr;
        key_nxt   = key_sr;
        enable    = 1'b0;
        last      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    data_nxt  = message;
                    key_nxt   = key_in;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                enable = ~hold;
                last   = ~hold & (cnt == LAST_CNT);
                if (!hold) begin
                    data_nxt = {data_sr[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    key_nxt  = {key_sr[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    if (cnt == LAST_CNT) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign in_byte  = data_sr[W-1 -: BYTE_W];
    assign key_byte = key_sr[W-1 -: BYTE_W];

endmodule
